// File: rtl/jp_scan_if.sv
// rtl/jp_scan_if.sv - NES joypad scanner with $4016/$4017 strobe/shift CPU register interface
// Polls both pads on a shared latch/clock pair and serves the CPU's serial read protocol.
module jp_scan_if #(
  parameter int CLK_DIV    = 150,
  parameter int POLL_TICKS = 2778
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       jp_data1,
  input  logic       jp_data2,
  output logic       jp_clk,
  output logic       jp_latch,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       cpu_sel,
  input  logic       cpu_din,
  output logic [7:0] cpu_dout,
  output logic [7:0] btn1,
  output logic [7:0] btn2,
  output logic       scan_done
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int POLL_W = $clog2(POLL_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_BIT_LO,
    S_BIT_HI
  } state_t;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  state_t            state_q;
  logic [POLL_W-1:0] poll_q;
  logic              phase_q;
  logic [2:0]        idx_q;
  logic [2:0]        idx_nxt;
  logic [7:0]        cap1_q, cap2_q;
  logic [7:0]        btn1_q, btn2_q;
  logic              jp_latch_q, jp_clk_q, scan_done_q;
  logic              strobe_q;
  logic [7:0]        sh1_q, sh2_q;
  logic [7:0]        cpu_dout_q;
  logic              rd_en;

  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    idx_nxt = idx_q + 3'd1;
    rd_en   = cpu_rd && !cpu_wr;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Each pad bit is captured on the edge that enters BIT_LO, i.e. after the
  // previous rising jp_clk has shifted the next button onto the data line.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      poll_q      <= '0;
      phase_q     <= 1'b0;
      idx_q       <= 3'd0;
      cap1_q      <= 8'h00;
      cap2_q      <= 8'h00;
      btn1_q      <= 8'h00;
      btn2_q      <= 8'h00;
      jp_latch_q  <= 1'b0;
      jp_clk_q    <= 1'b1;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (poll_q == POLL_LAST) begin
              poll_q     <= '0;
              phase_q    <= 1'b0;
              jp_latch_q <= 1'b1;
              state_q    <= S_LATCH;
            end else begin
              poll_q <= poll_q + POLL_W'(1);
            end
          end
          S_LATCH: begin
            if (phase_q) begin
              phase_q    <= 1'b0;
              idx_q      <= 3'd0;
              cap1_q[0]  <= ~jp_data1;
              cap2_q[0]  <= ~jp_data2;
              jp_latch_q <= 1'b0;
              jp_clk_q   <= 1'b0;
              state_q    <= S_BIT_LO;
            end else begin
              phase_q <= 1'b1;
            end
          end
          S_BIT_LO: begin
            jp_clk_q <= 1'b1;
            state_q  <= S_BIT_HI;
          end
          S_BIT_HI: begin
            if (idx_q == 3'd7) begin
              btn1_q      <= cap1_q;
              btn2_q      <= cap2_q;
              scan_done_q <= 1'b1;
              poll_q      <= '0;
              state_q     <= S_IDLE;
            end else begin
              idx_q           <= idx_nxt;
              cap1_q[idx_nxt] <= ~jp_data1;
              cap2_q[idx_nxt] <= ~jp_data2;
              jp_clk_q        <= 1'b0;
              state_q         <= S_BIT_LO;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // A write in the same cycle as a read wins; the read is dropped entirely.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      strobe_q   <= 1'b0;
      sh1_q      <= 8'h00;
      sh2_q      <= 8'h00;
      cpu_dout_q <= 8'h00;
    end else begin
      if (cpu_wr) begin
        strobe_q <= cpu_din;
      end
      if (strobe_q) begin
        sh1_q <= btn1_q;
        sh2_q <= btn2_q;
      end else if (rd_en) begin
        if (cpu_sel) begin
          sh2_q <= {1'b1, sh2_q[7:1]};
        end else begin
          sh1_q <= {1'b1, sh1_q[7:1]};
        end
      end
      if (rd_en) begin
        cpu_dout_q <= {7'b0100000, cpu_sel ? sh2_q[0] : sh1_q[0]};
      end
    end
  end

  assign jp_clk    = jp_clk_q;
  assign jp_latch  = jp_latch_q;
  assign btn1      = btn1_q;
  assign btn2      = btn2_q;
  assign scan_done = scan_done_q;
  assign cpu_dout  = cpu_dout_q;

endmodule
